mc_ctrl: RTL and testbench

Multi-cycle control unit for the next-generation MIPS core. It replaces the single-cycle decoder with a FETCH/DECODE/EXEC/MEM/WB state machine, and supports the existing instruction set plus bne. Instruction and data memory accesses use a req/ready handshake with variable latency and a parametrised wait timeout. It sits between the datapath and the memory ports and drives every datapath enable and mux select.

---
 rtl/mc_ctrl_pkg.sv | 81 ++++++++
 rtl/mc_decode.sv | 95 +++++++++
 rtl/mc_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_mc_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: FSM states, opcode/funct
// constants, datapath select codes and the one-hot instruction-class bit positions.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LBU   = 6'b100100;
    localparam logic [5:0] OP_LHU   = 6'b100101;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_SH    = 6'b101001;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] F_ADD    = 6'b100000;
    localparam logic [5:0] F_ADDU   = 6'b100001;
    localparam logic [5:0] F_SUB    = 6'b100010;
    localparam logic [5:0] F_SUBU   = 6'b100011;
    localparam logic [5:0] F_AND    = 6'b100100;
    localparam logic [5:0] F_OR     = 6'b100101;
    localparam logic [5:0] F_SLT    = 6'b101010;
    localparam logic [5:0] F_SLTU   = 6'b101011;

    localparam logic [2:0] ALU_NOP  = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;
    localparam logic [2:0] ALU_AND  = 3'd3;
    localparam logic [2:0] ALU_OR   = 3'd4;
    localparam logic [2:0] ALU_SLT  = 3'd5;
    localparam logic [2:0] ALU_SLTU = 3'd6;

    localparam logic [1:0] NPC_PLUS4  = 2'b00;
    localparam logic [1:0] NPC_BRANCH = 2'b01;
    localparam logic [1:0] NPC_JUMP   = 2'b10;

    localparam logic [1:0] GPR_RD = 2'b00;
    localparam logic [1:0] GPR_RT = 2'b01;
    localparam logic [1:0] GPR_RA = 2'b10;

    localparam logic [1:0] WD_ALU = 2'b00;
    localparam logic [1:0] WD_MEM = 2'b01;
    localparam logic [1:0] WD_PC  = 2'b10;

    localparam logic [2:0] LA_W  = 3'b000;
    localparam logic [2:0] LA_B  = 3'b001;
    localparam logic [2:0] LA_BU = 3'b010;
    localparam logic [2:0] LA_H  = 3'b011;
    localparam logic [2:0] LA_HU = 3'b100;

    localparam logic [1:0] MW_NONE = 2'b00;
    localparam logic [1:0] MW_SW   = 2'b01;
    localparam logic [1:0] MW_SB   = 2'b10;
    localparam logic [1:0] MW_SH   = 2'b11;

    // Bit positions inside the one-hot instruction class vector.
    localparam int CLS_N     = 9;
    localparam int CLS_RTYPE = 0;
    localparam int CLS_IALU  = 1;
    localparam int CLS_LOAD  = 2;
    localparam int CLS_STORE = 3;
    localparam int CLS_BEQ   = 4;
    localparam int CLS_BNE   = 5;
    localparam int CLS_J     = 6;
    localparam int CLS_JAL   = 7;
    localparam int CLS_ILL   = 8;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decoder: latched Op/Funct to a one-hot class plus the
// static per-instruction fields (ALU op, operand source, extension, load size, store code).
module mc_decode
    import mc_ctrl_pkg::*;
#(
    parameter int HAS_BNE = 1
) (
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    output logic [CLS_N-1:0] cls,
    output logic [2:0]       alu_op,
    output logic             alu_src,
    output logic             ext_op,
    output logic [2:0]       laddr,
    output logic [1:0]       mw_code
);

    always_comb begin
        cls     = '0;
        alu_op  = ALU_NOP;
        alu_src = 1'b0;
        ext_op  = 1'b0;
        laddr   = LA_W;
        mw_code = MW_NONE;

        case (op)
            OP_RTYPE: begin
                cls[CLS_RTYPE] = 1'b1;
                case (funct)
                    F_ADD, F_ADDU: alu_op = ALU_ADD;
                    F_SUB, F_SUBU: alu_op = ALU_SUB;
                    F_AND:         alu_op = ALU_AND;
                    F_OR:          alu_op = ALU_OR;
                    F_SLT:         alu_op = ALU_SLT;
                    F_SLTU:        alu_op = ALU_SLTU;
                    default: begin
                        cls          = '0;
                        cls[CLS_ILL] = 1'b1;
                    end
                endcase
            end
            OP_ADDI: begin
                cls[CLS_IALU] = 1'b1;
                alu_op        = ALU_ADD;
                alu_src       = 1'b1;
                ext_op        = 1'b1;
            end
            OP_ORI: begin
                cls[CLS_IALU] = 1'b1;
                alu_op        = ALU_OR;
                alu_src       = 1'b1;
            end
            OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU: begin
                cls[CLS_LOAD] = 1'b1;
                alu_op        = ALU_ADD;
                alu_src       = 1'b1;
                ext_op        = 1'b1;
                case (op)
                    OP_LB:   laddr = LA_B;
                    OP_LBU:  laddr = LA_BU;
                    OP_LH:   laddr = LA_H;
                    OP_LHU:  laddr = LA_HU;
                    default: laddr = LA_W;
                endcase
            end
            OP_SW, OP_SB, OP_SH: begin
                cls[CLS_STORE] = 1'b1;
                alu_op         = ALU_ADD;
                alu_src        = 1'b1;
                ext_op         = 1'b1;
                case (op)
                    OP_SB:   mw_code = MW_SB;
                    OP_SH:   mw_code = MW_SH;
                    default: mw_code = MW_SW;
                endcase
            end
            OP_BEQ: begin
                cls[CLS_BEQ] = 1'b1;
                alu_op       = ALU_SUB;
            end
            OP_BNE: begin
                if (HAS_BNE != 0) begin
                    cls[CLS_BNE] = 1'b1;
                    alu_op       = ALU_SUB;
                end else begin
                    cls[CLS_ILL] = 1'b1;
                end
            end
            OP_J:    cls[CLS_J]   = 1'b1;
            OP_JAL:  cls[CLS_JAL] = 1'b1;
            default: cls[CLS_ILL] = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with req/ready
// memory handshakes, a wait-timeout counter and all datapath enables and selects.
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int ALUOP_W  = 3,
    parameter int MAX_WAIT = 15,
    parameter int HAS_BNE  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         Op,
    input  logic [5:0]         Funct,
    input  logic               Zero,
    input  logic               mem_ready,
    output logic               imem_req,
    output logic               dmem_req,
    output logic               PCWrite,
    output logic               IRWrite,
    output logic               RegWrite,
    output logic               MemRead,
    output logic [1:0]         MemWrite,
    output logic               EXTOp,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic [1:0]         NPCOp,
    output logic               ALUSrc,
    output logic [1:0]         GPRSel,
    output logic [1:0]         WDSel,
    output logic [2:0]         LAddr,
    output logic               instr_done,
    output logic               illegal,
    output logic               bus_err
);

    localparam int CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

    state_t             state;
    state_t             state_nx;
    logic [5:0]         op_q;
    logic [5:0]         funct_q;
    logic [CNT_W-1:0]   wait_cnt;
    logic [CNT_W-1:0]   wait_cnt_nx;
    logic               wait_hit;

    logic [CLS_N-1:0]   cls;
    logic [2:0]         alu_op;
    logic               alu_src;
    logic               ext_op;
    logic [2:0]         laddr;
    logic [1:0]         mw_code;

    mc_decode #(
        .HAS_BNE (HAS_BNE)
    ) u_decode (
        .op      (op_q),
        .funct   (funct_q),
        .cls     (cls),
        .alu_op  (alu_op),
        .alu_src (alu_src),
        .ext_op  (ext_op),
        .laddr   (laddr),
        .mw_code (mw_code)
    );

    // A timeout of zero never fires; the counter then simply wraps.
    assign wait_hit = (MAX_WAIT != 0) && (wait_cnt == CNT_W'(MAX_WAIT));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_FETCH;
            op_q     <= '0;
            funct_q  <= '0;
            wait_cnt <= '0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_cnt_nx;
            if (IRWrite) begin
                op_q    <= Op;
                funct_q <= Funct;
            end
        end
    end

    always_comb begin
        state_nx    = state;
        wait_cnt_nx = '0;
        imem_req    = 1'b0;
        dmem_req    = 1'b0;
        PCWrite     = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = MW_NONE;
        EXTOp       = 1'b0;
        ALUOp       = '0;
        NPCOp       = NPC_PLUS4;
        ALUSrc      = 1'b0;
        GPRSel      = GPR_RD;
        WDSel       = WD_ALU;
        LAddr       = LA_W;
        instr_done  = 1'b0;
        illegal     = 1'b0;
        bus_err     = 1'b0;

        if (!rst) begin
            // ALU controls stay valid from EXEC through WB so the result path is stable.
            if (state == S_EXEC || state == S_MEM || state == S_WB) begin
                ALUOp  = ALUOP_W'(alu_op);
                ALUSrc = alu_src;
                EXTOp  = ext_op;
            end

            case (state)
                S_FETCH: begin
                    imem_req = 1'b1;
                    if (mem_ready) begin
                        IRWrite  = 1'b1;
                        PCWrite  = 1'b1;
                        state_nx = S_DECODE;
                    end else if (wait_hit) begin
                        bus_err = 1'b1;
                    end else begin
                        wait_cnt_nx = wait_cnt + 1'b1;
                    end
                end
                S_DECODE: begin
                    state_nx = S_EXEC;
                    if (cls[CLS_J] || cls[CLS_JAL]) begin
                        PCWrite    = 1'b1;
                        NPCOp      = NPC_JUMP;
                        instr_done = 1'b1;
                        state_nx   = S_FETCH;
                    end
                    if (cls[CLS_JAL]) begin
                        RegWrite = 1'b1;
                        GPRSel   = GPR_RA;
                        WDSel    = WD_PC;
                    end
                    if (cls[CLS_ILL]) begin
                        illegal  = 1'b1;
                        state_nx = S_FETCH;
                    end
                end
                S_EXEC: begin
                    if (cls[CLS_BEQ] || cls[CLS_BNE]) begin
                        NPCOp      = NPC_BRANCH;
                        PCWrite    = cls[CLS_BEQ] ? Zero : ~Zero;
                        instr_done = 1'b1;
                        state_nx   = S_FETCH;
                    end else if (cls[CLS_LOAD] || cls[CLS_STORE]) begin
                        state_nx = S_MEM;
                    end else if (cls[CLS_RTYPE] || cls[CLS_IALU]) begin
                        state_nx = S_WB;
                    end else begin
                        state_nx = S_FETCH;
                    end
                end
                S_MEM: begin
                    dmem_req = 1'b1;
                    MemRead  = cls[CLS_LOAD];
                    MemWrite = mw_code;
                    LAddr    = laddr;
                    if (mem_ready) begin
                        if (cls[CLS_STORE]) begin
                            instr_done = 1'b1;
                            state_nx   = S_FETCH;
                        end else begin
                            state_nx = S_WB;
                        end
                    end else if (wait_hit) begin
                        // The access is abandoned; the already-advanced PC is kept.
                        bus_err  = 1'b1;
                        state_nx = S_FETCH;
                    end else begin
                        wait_cnt_nx = wait_cnt + 1'b1;
                    end
                end
                S_WB: begin
                    RegWrite   = 1'b1;
                    GPRSel     = cls[CLS_RTYPE] ? GPR_RD : GPR_RT;
                    WDSel      = cls[CLS_LOAD] ? WD_MEM : WD_ALU;
                    LAddr      = laddr;
                    instr_done = 1'b1;
                    state_nx   = S_FETCH;
                end
                default: state_nx = S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Cycle-accurate bench for mc_ctrl: an instruction table plus hand-written timeout and
// reset sequences, with expected output words queued at drive time and popped at sample time.
module tb_mc_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       Zero;
    logic       mem_ready;
    logic       imem_req, dmem_req, PCWrite, IRWrite, RegWrite, MemRead;
    logic [1:0] MemWrite;
    logic       EXTOp;
    logic [2:0] ALUOp;
    logic [1:0] NPCOp;
    logic       ALUSrc;
    logic [1:0] GPRSel, WDSel;
    logic [2:0] LAddr;
    logic       instr_done, illegal, bus_err;

    always #5 clk = ~clk;

    mc_ctrl #(
        .ALUOP_W  (3),
        .MAX_WAIT (3),
        .HAS_BNE  (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .Op         (Op),
        .Funct      (Funct),
        .Zero       (Zero),
        .mem_ready  (mem_ready),
        .imem_req   (imem_req),
        .dmem_req   (dmem_req),
        .PCWrite    (PCWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .EXTOp      (EXTOp),
        .ALUOp      (ALUOp),
        .NPCOp      (NPCOp),
        .ALUSrc     (ALUSrc),
        .GPRSel     (GPRSel),
        .WDSel      (WDSel),
        .LAddr      (LAddr),
        .instr_done (instr_done),
        .illegal    (illegal),
        .bus_err    (bus_err)
    );

    typedef struct packed {
        logic       imem;
        logic       dmem;
        logic       pcw;
        logic       irw;
        logic       rw;
        logic       mr;
        logic [1:0] mw;
        logic       ext;
        logic [2:0] alu;
        logic [1:0] npc;
        logic       src;
        logic [1:0] gpr;
        logic [1:0] wd;
        logic [2:0] la;
        logic       done;
        logic       ill;
        logic       berr;
    } out_t;

    typedef enum int {K_ALU, K_LOAD, K_STORE, K_BR, K_J, K_JAL, K_ILL} kind_t;
    typedef enum int {PH_F, PH_D, PH_E, PH_M, PH_W} phase_t;

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [5:0] funct;
        logic       zero;
        int         fwait;
        int         mwait;
        kind_t      kind;
        logic [2:0] alu;
        logic       src;
        logic       ext;
        logic [1:0] gpr;
        logic [1:0] wd;
        logic [2:0] la;
        logic [1:0] mw;
        logic       pcw;
    } vec_t;

    out_t  act;
    out_t  exp_q[$];
    string nm_q[$];
    vec_t  tbl[$];
    int    compared   = 0;
    int    mismatched = 0;
    int    cycnum     = 0;

    assign act = {imem_req, dmem_req, PCWrite, IRWrite, RegWrite, MemRead, MemWrite, EXTOp,
                  ALUOp, NPCOp, ALUSrc, GPRSel, WDSel, LAddr, instr_done, illegal, bus_err};

    function automatic vec_t mkv(input string n, input logic [5:0] o, input logic [5:0] f,
                                 input logic z, input int fw, input int mwt, input kind_t k,
                                 input logic [2:0] a, input logic s, input logic e,
                                 input logic [1:0] g, input logic [1:0] w, input logic [2:0] l,
                                 input logic [1:0] m, input logic p);
        vec_t v;
        v.name = n; v.op = o; v.funct = f; v.zero = z; v.fwait = fw; v.mwait = mwt;
        v.kind = k; v.alu = a; v.src = s; v.ext = e; v.gpr = g; v.wd = w; v.la = l;
        v.mw = m; v.pcw = p;
        return v;
    endfunction

    // Expected output word for one cycle of an instruction in a given phase.
    function automatic out_t ex_phase(input phase_t p, input vec_t v, input logic rdy);
        out_t e = '0;
        case (p)
            PH_F: begin
                e.imem = 1'b1;
                if (rdy) begin e.irw = 1'b1; e.pcw = 1'b1; end
            end
            PH_D: begin
                if (v.kind == K_J || v.kind == K_JAL) begin
                    e.pcw = 1'b1; e.npc = 2'b10; e.done = 1'b1;
                end
                if (v.kind == K_JAL) begin e.rw = 1'b1; e.gpr = 2'b10; e.wd = 2'b10; end
                if (v.kind == K_ILL) e.ill = 1'b1;
            end
            PH_E: begin
                e.alu = v.alu; e.src = v.src; e.ext = v.ext;
                if (v.kind == K_BR) begin e.npc = 2'b01; e.pcw = v.pcw; e.done = 1'b1; end
            end
            PH_M: begin
                e.alu = v.alu; e.src = v.src; e.ext = v.ext;
                e.dmem = 1'b1; e.mr = (v.kind == K_LOAD); e.mw = v.mw; e.la = v.la;
                if (rdy && v.kind == K_STORE) e.done = 1'b1;
            end
            PH_W: begin
                e.alu = v.alu; e.src = v.src; e.ext = v.ext;
                e.rw = 1'b1; e.gpr = v.gpr; e.wd = v.wd; e.la = v.la; e.done = 1'b1;
            end
            default: e = '0;
        endcase
        return e;
    endfunction

    task automatic check_one();
        out_t  e;
        string n;
        if (exp_q.size() == 0) begin
            mismatched++;
            $display("FAIL scoreboard empty at cycle %0d", cycnum);
            return;
        end
        e = exp_q.pop_front();
        n = nm_q.pop_front();
        compared++;
        if (act !== e) begin
            mismatched++;
            $display("FAIL %s cycle %0d: got %h required %h", n, cycnum, act, e);
        end
    endtask

    // Drive one cycle at the falling edge, queue its expectation, sample 1 time unit later.
    task automatic cyc(input logic r, input logic [5:0] o, input logic [5:0] f, input logic z,
                       input logic rdy, input out_t e, input string n);
        rst = r; Op = o; Funct = f; Zero = z; mem_ready = rdy;
        exp_q.push_back(e);
        nm_q.push_back(n);
        #1;
        check_one();
        @(negedge clk);
        cycnum++;
    endtask

    function automatic logic [5:0] rnd6();
        return 6'($urandom());
    endfunction

    task automatic run_vec(input vec_t v);
        for (int i = 0; i < v.fwait; i++)
            cyc(1'b0, rnd6(), rnd6(), v.zero, 1'b0, ex_phase(PH_F, v, 1'b0), {v.name, " fetch-wait"});
        cyc(1'b0, v.op, v.funct, v.zero, 1'b1, ex_phase(PH_F, v, 1'b1), {v.name, " fetch"});
        cyc(1'b0, rnd6(), rnd6(), v.zero, 1'($urandom()), ex_phase(PH_D, v, 1'b0), {v.name, " decode"});
        if (v.kind == K_J || v.kind == K_JAL || v.kind == K_ILL) return;
        cyc(1'b0, rnd6(), rnd6(), v.zero, 1'($urandom()), ex_phase(PH_E, v, 1'b0), {v.name, " exec"});
        if (v.kind == K_BR) return;
        if (v.kind == K_LOAD || v.kind == K_STORE) begin
            for (int i = 0; i < v.mwait; i++)
                cyc(1'b0, rnd6(), rnd6(), v.zero, 1'b0, ex_phase(PH_M, v, 1'b0), {v.name, " mem-wait"});
            cyc(1'b0, rnd6(), rnd6(), v.zero, 1'b1, ex_phase(PH_M, v, 1'b1), {v.name, " mem"});
        end
        if (v.kind == K_STORE) return;
        cyc(1'b0, rnd6(), rnd6(), v.zero, 1'($urandom()), ex_phase(PH_W, v, 1'b0), {v.name, " wb"});
    endtask

    initial begin
        out_t e;
        vec_t sb;
        vec_t sw;

        //            name    op         funct      z  fw mw kind     alu   s  e  gpr    wd     la     mw     pcw
        tbl.push_back(mkv("addu", 6'b000000, 6'b100001, 0, 0, 0, K_ALU,   3'd1, 0, 0, 2'b00, 2'b00, 3'b000, 2'b00, 0));
        tbl.push_back(mkv("subu", 6'b000000, 6'b100011, 0, 1, 0, K_ALU,   3'd2, 0, 0, 2'b00, 2'b00, 3'b000, 2'b00, 0));
        tbl.push_back(mkv("and",  6'b000000, 6'b100100, 0, 0, 0, K_ALU,   3'd3, 0, 0, 2'b00, 2'b00, 3'b000, 2'b00, 0));
        tbl.push_back(mkv("slt",  6'b000000, 6'b101010, 0, 0, 0, K_ALU,   3'd5, 0, 0, 2'b00, 2'b00, 3'b000, 2'b00, 0));
        tbl.push_back(mkv("sltu", 6'b000000, 6'b101011, 0, 0, 0, K_ALU,   3'd6, 0, 0, 2'b00, 2'b00, 3'b000, 2'b00, 0));
        tbl.push_back(mkv("addi", 6'b001000, 6'b000000, 0, 0, 0, K_ALU,   3'd1, 1, 1, 2'b01, 2'b00, 3'b000, 2'b00, 0));
        tbl.push_back(mkv("ori",  6'b001101, 6'b000000, 0, 0, 0, K_ALU,   3'd4, 1, 0, 2'b01, 2'b00, 3'b000, 2'b00, 0));
        tbl.push_back(mkv("lw",   6'b100011, 6'b000000, 0, 0, 0, K_LOAD,  3'd1, 1, 1, 2'b01, 2'b01, 3'b000, 2'b00, 0));
        tbl.push_back(mkv("lh",   6'b100001, 6'b000000, 0, 0, 2, K_LOAD,  3'd1, 1, 1, 2'b01, 2'b01, 3'b011, 2'b00, 0));
        tbl.push_back(mkv("lb",   6'b100000, 6'b000000, 0, 0, 0, K_LOAD,  3'd1, 1, 1, 2'b01, 2'b01, 3'b001, 2'b00, 0));
        tbl.push_back(mkv("lbu",  6'b100100, 6'b000000, 0, 0, 1, K_LOAD,  3'd1, 1, 1, 2'b01, 2'b01, 3'b010, 2'b00, 0));
        tbl.push_back(mkv("lhu",  6'b100101, 6'b000000, 0, 0, 0, K_LOAD,  3'd1, 1, 1, 2'b01, 2'b01, 3'b100, 2'b00, 0));
        tbl.push_back(mkv("sw",   6'b101011, 6'b000000, 0, 0, 0, K_STORE, 3'd1, 1, 1, 2'b00, 2'b00, 3'b000, 2'b01, 0));
        tbl.push_back(mkv("sb",   6'b101000, 6'b000000, 0, 0, 1, K_STORE, 3'd1, 1, 1, 2'b00, 2'b00, 3'b000, 2'b10, 0));
        tbl.push_back(mkv("sh",   6'b101001, 6'b000000, 0, 0, 2, K_STORE, 3'd1, 1, 1, 2'b00, 2'b00, 3'b000, 2'b11, 0));
        tbl.push_back(mkv("beq1", 6'b000100, 6'b000000, 1, 0, 0, K_BR,    3'd2, 0, 0, 2'b00, 2'b00, 3'b000, 2'b00, 1));
        tbl.push_back(mkv("bne1", 6'b000101, 6'b000000, 1, 0, 0, K_BR,    3'd2, 0, 0, 2'b00, 2'b00, 3'b000, 2'b00, 0));
        tbl.push_back(mkv("bne0", 6'b000101, 6'b000000, 0, 0, 0, K_BR,    3'd2, 0, 0, 2'b00, 2'b00, 3'b000, 2'b00, 1));
        tbl.push_back(mkv("beq0", 6'b000100, 6'b000000, 0, 0, 0, K_BR,    3'd2, 0, 0, 2'b00, 2'b00, 3'b000, 2'b00, 0));
        tbl.push_back(mkv("j",    6'b000010, 6'b000000, 0, 0, 0, K_J,     3'd0, 0, 0, 2'b00, 2'b00, 3'b000, 2'b00, 0));
        tbl.push_back(mkv("jal",  6'b000011, 6'b000000, 0, 0, 0, K_JAL,   3'd0, 0, 0, 2'b00, 2'b00, 3'b000, 2'b00, 0));
        tbl.push_back(mkv("ill",  6'b111111, 6'b000000, 0, 0, 0, K_ILL,   3'd0, 0, 0, 2'b00, 2'b00, 3'b000, 2'b00, 0));

        rst = 1'b1; Op = '0; Funct = '0; Zero = 1'b0; mem_ready = 1'b0;
        repeat (2) @(negedge clk);

        // Reset holds every output low, even with ready asserted.
        cyc(1'b1, rnd6(), rnd6(), 1'b1, 1'b1, '0, "reset");
        cyc(1'b1, rnd6(), rnd6(), 1'b0, 1'b1, '0, "reset");
        e = '0; e.imem = 1'b1;
        cyc(1'b0, rnd6(), rnd6(), 1'b0, 1'b0, e, "post-reset fetch");

        for (int i = 0; i < tbl.size(); i++)
            run_vec(tbl[i]);

        // sb with no answer: bus error on the fourth MEM cycle, then FETCH timeout too.
        sb = mkv("sb-timeout", 6'b101000, 6'b000000, 0, 0, 0, K_STORE,
                 3'd1, 1, 1, 2'b00, 2'b00, 3'b000, 2'b10, 0);
        cyc(1'b0, sb.op, sb.funct, 1'b0, 1'b1, ex_phase(PH_F, sb, 1'b1), "sb-timeout fetch");
        cyc(1'b0, rnd6(), rnd6(), 1'b0, 1'b0, ex_phase(PH_D, sb, 1'b0), "sb-timeout decode");
        cyc(1'b0, rnd6(), rnd6(), 1'b0, 1'b0, ex_phase(PH_E, sb, 1'b0), "sb-timeout exec");
        for (int i = 0; i < 4; i++) begin
            e = ex_phase(PH_M, sb, 1'b0);
            e.berr = (i == 3);
            cyc(1'b0, rnd6(), rnd6(), 1'b0, 1'b0, e, "sb-timeout mem");
        end
        for (int i = 0; i < 4; i++) begin
            e = '0; e.imem = 1'b1; e.berr = (i == 3);
            cyc(1'b0, rnd6(), rnd6(), 1'b0, 1'b0, e, "fetch-timeout");
        end
        run_vec(tbl[19]);

        // Reset in the middle of a sw MEM wait.
        sw = tbl[12];
        cyc(1'b0, sw.op, sw.funct, 1'b0, 1'b1, ex_phase(PH_F, sw, 1'b1), "sw-rst fetch");
        cyc(1'b0, rnd6(), rnd6(), 1'b0, 1'b0, ex_phase(PH_D, sw, 1'b0), "sw-rst decode");
        cyc(1'b0, rnd6(), rnd6(), 1'b0, 1'b0, ex_phase(PH_E, sw, 1'b0), "sw-rst exec");
        cyc(1'b0, rnd6(), rnd6(), 1'b0, 1'b0, ex_phase(PH_M, sw, 1'b0), "sw-rst mem-wait");
        cyc(1'b1, rnd6(), rnd6(), 1'b0, 1'b1, '0, "sw-rst reset");
        e = '0; e.imem = 1'b1;
        cyc(1'b0, rnd6(), rnd6(), 1'b0, 1'b0, e, "sw-rst refetch");
        run_vec(tbl[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
